abs_peak_tracker: RTL



---
 rtl/abs_peak_tracker.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/abs_peak_tracker.sv
// abs_peak_tracker: per-channel signed min/max tracking over one accumulation
// window, then a pipelined reduction of all channels to a single max |x|.
// Optional build macro: ABS_PEAK_INDEX_EN adds the peak_ch output (channel
// index of the winning max_abs, lowest index on ties).

// One channel: running signed min/max plus the absolute-peak of that channel.
module abs_peak_lane #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,     // first sample of a window: load both
    input  logic              upd,    // later sample: widen the range
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] a
);
    logic signed [DATA_W-1:0] min_q, max_q, min_d, max_d, xs;
    logic signed [DATA_W:0]   max_e, neg_e;

    assign xs = x;

    // next-state of the tracked range
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (ld) begin
            min_d = xs;
            max_d = xs;
        end else if (upd) begin
            if (xs < min_q) min_d = xs;
            if (xs > max_q) max_d = xs;
        end
    end

    // range registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    // One extra bit so -(-2^(W-1)) is representable; truncation keeps 2^(W-1).
    assign max_e = {max_q[DATA_W-1], max_q};
    assign neg_e = -{min_q[DATA_W-1], min_q};
    assign a     = (max_e >= neg_e) ? max_e[DATA_W-1:0] : neg_e[DATA_W-1:0];
endmodule

module abs_peak_tracker #(
    parameter int  DATA_W = 32,
    parameter int  NUM_CH = 16,
    localparam int LVL    = $clog2(NUM_CH),
    localparam int IW     = (LVL > 0) ? LVL : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     win_last,
    input  logic [NUM_CH*DATA_W-1:0] conv_data,
    output logic [DATA_W-1:0]        max_abs,
    output logic                     out_valid,
    output logic                     busy
`ifdef ABS_PEAK_INDEX_EN
   ,output logic [IW-1:0]            peak_ch
`endif
);
    // tree width padded to a power of two; pads are 0 and never win
    localparam int P = 1 << LVL;

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_ABS, S_REDUCE, S_DONE} state_t;

    state_t            state_q;
    logic              first_q, out_valid_q, busy_q;
    logic [IW-1:0]     vld_pipe_q, vld_pipe_d;
    logic [DATA_W-1:0] max_abs_q, max_abs_d;
    logic              acc, take, ld, upd, fin_ld;
    logic [DATA_W-1:0] fin_v;
    logic [P-1:0][DATA_W-1:0] abs_v;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_ACCUM);
    assign acc      = in_valid & in_ready;
    assign take     = acc & ~clr;           // clr drops a same-cycle sample
    assign ld       = take & first_q;
    assign upd      = take & ~first_q;

    // channel lanes; tree slots beyond NUM_CH pad with zero
    genvar c;
    for (c = 0; c < P; c++) begin : g_ch
        if (c < NUM_CH) begin : g_lane
            abs_peak_lane #(.DATA_W(DATA_W)) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .ld    (ld),
                .upd   (upd),
                .x     (conv_data[c*DATA_W +: DATA_W]),
                .a     (abs_v[c])
            );
        end else begin : g_pad
            assign abs_v[c] = '0;
        end
    end

    // Comparator tree. Level 0 is the abs vector; level k combines registered
    // level k-1 pairs. Levels 0..LVL-1 are registered, level LVL feeds max_abs.
    genvar k;
    for (k = 0; k <= LVL; k++) begin : g_lvl
        localparam int N = P >> k;
        logic [N-1:0][DATA_W-1:0] v;
`ifdef ABS_PEAK_INDEX_EN
        logic [N-1:0][IW-1:0]     ix;
`endif
        if (k == 0) begin : g_src
            assign v = abs_v;
`ifdef ABS_PEAK_INDEX_EN
            // each slot starts tagged with its own channel number
            always_comb begin
                for (int i = 0; i < N; i++) ix[i] = IW'(i);
            end
`endif
        end else begin : g_cmp
            logic [2*N-1:0][DATA_W-1:0] pv;
            assign pv = g_lvl[k-1].g_reg.r_q;
`ifdef ABS_PEAK_INDEX_EN
            logic [2*N-1:0][IW-1:0] pix;
            assign pix = g_lvl[k-1].g_reg.ix_q;
`endif
            // left wins ties so the lowest channel index survives
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    if (pv[2*i] >= pv[2*i+1]) begin
                        v[i] = pv[2*i];
`ifdef ABS_PEAK_INDEX_EN
                        ix[i] = pix[2*i];
`endif
                    end else begin
                        v[i] = pv[2*i+1];
`ifdef ABS_PEAK_INDEX_EN
                        ix[i] = pix[2*i+1];
`endif
                    end
                end
            end
        end
        if (k < LVL) begin : g_reg
            logic [N-1:0][DATA_W-1:0] r_q;
`ifdef ABS_PEAK_INDEX_EN
            logic [N-1:0][IW-1:0]     ix_q;
`endif
            // free-running level register; inputs are static while reducing
            always_ff @(posedge clk) begin
                r_q <= v;
`ifdef ABS_PEAK_INDEX_EN
                ix_q <= ix;
`endif
            end
        end
    end

    assign fin_v = g_lvl[LVL].v[0];

    // one-hot marker walking down the tree, one level per REDUCE cycle
    always_comb begin
        vld_pipe_d = (vld_pipe_q << 1) | IW'(state_q == S_ABS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) vld_pipe_q <= '0;
        else        vld_pipe_q <= vld_pipe_d;
    end

    // final tree level is ready: leave ABS (flat tree) or REDUCE
    assign fin_ld = ((state_q == S_ABS) && (LVL == 0)) ||
                    ((state_q == S_REDUCE) && vld_pipe_q[IW-1]);

    // control FSM with registered out_valid/busy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (clr) begin
                        state_q <= S_IDLE;
                        first_q <= 1'b1;
                    end else if (acc) begin
                        first_q <= 1'b0;
                        if (win_last) begin
                            state_q <= S_ABS;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end
                end
                S_ABS, S_REDUCE: begin
                    if (fin_ld) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= S_REDUCE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    first_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign max_abs_d = fin_ld ? fin_v : max_abs_q;

    // result register, held until the next window completes
    always_ff @(posedge clk) begin
        if (!rst_n) max_abs_q <= '0;
        else        max_abs_q <= max_abs_d;
    end

`ifdef ABS_PEAK_INDEX_EN
    logic [IW-1:0] peak_q;

    // winning channel index, captured with max_abs
    always_ff @(posedge clk) begin
        if (!rst_n)      peak_q <= '0;
        else if (fin_ld) peak_q <= g_lvl[LVL].ix[0];
    end

    assign peak_ch = peak_q;
`endif

    assign max_abs   = max_abs_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
endmodule
